// File: rtl/perceptron_trainer.sv
// perceptron_trainer: sequential training controller for a two-input neuron.
// Accepts labelled samples over valid/ready. Each sample drives the neuron for
// one cycle. The activation result is then used to apply the perceptron
// learning rule to w1/w2/wb. Per-epoch error counts and a convergence flag are
// also tracked.
// Optional feature macro: PERCEPTRON_TRAINER_SAT_EN (saturating weight update).
// Handshake: a sample transfers on a rising clk edge where sample_valid and
// sample_ready are both high. sample_ready is high only in IDLE, so the sample
// inputs only need to be stable on that edge.
module perceptron_trainer #(
    parameter int SIGN        = 1,
    parameter int Q_M         = 15,
    parameter int Q_N         = 16,
    parameter int NUM_SAMPLES = 4,
    parameter logic [SIGN+Q_M+Q_N-1:0] LR      = 32'h0000_8000,
    parameter logic [SIGN+Q_M+Q_N-1:0] BIAS_IN = 32'h0001_0000,
    parameter logic [SIGN+Q_M+Q_N-1:0] W1_INIT = '0,
    parameter logic [SIGN+Q_M+Q_N-1:0] W2_INIT = '0,
    parameter logic [SIGN+Q_M+Q_N-1:0] WB_INIT = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               train_en,
    input  logic                               sample_valid,
    output logic                               sample_ready,
    input  logic [SIGN+Q_M+Q_N-1:0]            sample_x1,
    input  logic [SIGN+Q_M+Q_N-1:0]            sample_x2,
    input  logic                               sample_target,
    output logic [SIGN+Q_M+Q_N-1:0]            x1_out,
    output logic [SIGN+Q_M+Q_N-1:0]            x2_out,
    output logic [SIGN+Q_M+Q_N-1:0]            w1_out,
    output logic [SIGN+Q_M+Q_N-1:0]            w2_out,
    output logic [SIGN+Q_M+Q_N-1:0]            wb_out,
    input  logic [SIGN+Q_M+Q_N-1:0]            neuron_out,
    output logic                               result_valid,
    output logic                               result_pred,
    output logic                               result_error,
    output logic                               epoch_done,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]   epoch_errors,
    output logic                               converged
);

    localparam int W  = SIGN + Q_M + Q_N;
    localparam int CW = $clog2(NUM_SAMPLES + 1);
    localparam logic [W-1:0] ONE = W'(1) << Q_N;

    typedef enum logic [1:0] {IDLE, EVAL, UPDATE} state_t;

    state_t         state, state_next;
    logic           target_q;
    logic [CW-1:0]  sample_cnt;
    logic [CW-1:0]  err_cnt;
    logic           last_sample;
    logic           pred_now;
    logic [W-1:0]   d1, d2, db;

    // Fixed-point multiply: full signed product, arithmetic shift, keep low W bits.
    function automatic logic [W-1:0] fx(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        p = p >>> Q_N;
        return p[W-1:0];
    endfunction

    // Weight step: add or subtract the delta, clamping or wrapping on overflow.
    function automatic logic [W-1:0] wstep(input logic [W-1:0] w, input logic [W-1:0] d,
                                           input logic sub);
`ifdef PERCEPTRON_TRAINER_SAT_EN
        logic [W:0] s;
        s = sub ? ({w[W-1], w} - {d[W-1], d}) : ({w[W-1], w} + {d[W-1], d});
        if (s[W] != s[W-1])
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            return s[W-1:0];
`else
        return sub ? (w - d) : (w + d);
`endif
    endfunction

    assign pred_now    = (neuron_out == ONE);
    assign last_sample = (sample_cnt == CW'(NUM_SAMPLES - 1));
    assign d1          = fx(LR, x1_out);
    assign d2          = fx(LR, x2_out);
    assign db          = fx(LR, BIAS_IN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and the per-state strobes.
    always_comb begin
        state_next   = state;
        sample_ready = 1'b0;
        result_valid = 1'b0;
        epoch_done   = 1'b0;
        case (state)
            IDLE: begin
                sample_ready = 1'b1;
                if (sample_valid) state_next = EVAL;
            end
            EVAL:   state_next = UPDATE;
            UPDATE: begin
                result_valid = 1'b1;
                epoch_done   = last_sample;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sample capture, prediction capture, weight learning and epoch bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            x1_out       <= '0;
            x2_out       <= '0;
            target_q     <= 1'b0;
            w1_out       <= W1_INIT;
            w2_out       <= W2_INIT;
            wb_out       <= WB_INIT;
            result_pred  <= 1'b0;
            result_error <= 1'b0;
            sample_cnt   <= '0;
            err_cnt      <= '0;
            epoch_errors <= '0;
            converged    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        x1_out   <= sample_x1;
                        x2_out   <= sample_x2;
                        target_q <= sample_target;
                    end
                end
                EVAL: begin
                    result_pred  <= pred_now;
                    result_error <= (pred_now != target_q);
                end
                UPDATE: begin
                    // target=1 pulls weights up, target=0 pushes them down.
                    if (train_en && result_error) begin
                        w1_out <= wstep(w1_out, d1, !target_q);
                        w2_out <= wstep(w2_out, d2, !target_q);
                        wb_out <= wstep(wb_out, db, !target_q);
                    end
                    if (last_sample) begin
                        epoch_errors <= err_cnt + CW'(result_error);
                        converged    <= (err_cnt == '0) && !result_error;
                        sample_cnt   <= '0;
                        err_cnt      <= '0;
                    end else begin
                        sample_cnt <= sample_cnt + CW'(1);
                        err_cnt    <= err_cnt + CW'(result_error);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed table, random and training checks of perceptron_trainer.
module tb_perceptron_trainer;

    localparam logic [31:0] LR   = 32'h0000_8000;
    localparam logic [31:0] BIAS = 32'h0001_0000;
    localparam logic [31:0] ONEF = 32'h0001_0000;
    localparam int          NS   = 4;

    logic        clk = 1'b0;
    logic        rst, train_en, sample_valid, sample_target;
    logic [31:0] sample_x1, sample_x2, neuron_out, nout_drv;
    logic        use_neuron;

    logic        sample_ready, result_valid, result_pred, result_error, epoch_done, converged;
    logic [31:0] x1_out, x2_out, w1_out, w2_out, wb_out;
    logic [2:0]  epoch_errors;

    logic        b_sample_ready, b_result_valid, b_result_pred, b_result_error, b_epoch_done, b_converged;
    logic [31:0] b_x1_out, b_x2_out, b_w1_out, b_w2_out, b_wb_out;
    logic [2:0]  b_epoch_errors;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_w1, m_w2, m_wb;
    int          m_cnt, m_err, m_eerr;
    logic        m_conv;
    logic        e_pred, e_err, e_edone;

    // observations captured by the driver
    logic        obs_pred, obs_err, obs_edone, obs_conv;
    logic [31:0] obs_w1, obs_w2, obs_wb;
    logic [2:0]  obs_eerr;

    typedef struct {
        logic [31:0] x1, x2;
        logic        t, te;
        logic [31:0] nout;
        logic        pred, err, edone;
        logic [31:0] w1, w2, wb;
        logic [2:0]  eerr;
        logic        conv;
    } vec_t;
    vec_t tbl[4];

    perceptron_trainer dut (
        .clk(clk), .rst(rst), .train_en(train_en),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_x1(sample_x1), .sample_x2(sample_x2), .sample_target(sample_target),
        .x1_out(x1_out), .x2_out(x2_out), .w1_out(w1_out), .w2_out(w2_out), .wb_out(wb_out),
        .neuron_out(neuron_out), .result_valid(result_valid), .result_pred(result_pred),
        .result_error(result_error), .epoch_done(epoch_done), .epoch_errors(epoch_errors),
        .converged(converged)
    );

    perceptron_trainer #(.LR(32'h0001_0000), .W1_INIT(32'h7FFF_0000)) dut_b (
        .clk(clk), .rst(rst), .train_en(train_en),
        .sample_valid(sample_valid), .sample_ready(b_sample_ready),
        .sample_x1(sample_x1), .sample_x2(sample_x2), .sample_target(sample_target),
        .x1_out(b_x1_out), .x2_out(b_x2_out), .w1_out(b_w1_out), .w2_out(b_w2_out),
        .wb_out(b_wb_out), .neuron_out(neuron_out), .result_valid(b_result_valid),
        .result_pred(b_result_pred), .result_error(b_result_error),
        .epoch_done(b_epoch_done), .epoch_errors(b_epoch_errors), .converged(b_converged)
    );

    always #5 clk = ~clk;

    // Q15.16 product, truncated toward -inf, low 32 bits
    function automatic logic [31:0] fxm(logic [31:0] a, logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 16;
        return p[31:0];
    endfunction

    function automatic logic [31:0] wupd(logic [31:0] w, logic [31:0] d, logic sub);
        longint r;
        r = longint'($signed(w)) + (sub ? -longint'($signed(d)) : longint'($signed(d)));
`ifdef PERCEPTRON_TRAINER_SAT_EN
        if (r > longint'(32'h7FFF_FFFF)) r = longint'(32'h7FFF_FFFF);
        if (r < -longint'(32'h8000_0000)) r = -longint'(32'h8000_0000);
`endif
        return r[31:0];
    endfunction

    // step-activation neuron: 1.0 when w1*x1 + w2*x2 + wb is strictly positive
    function automatic logic [31:0] neuron(logic [31:0] w1, logic [31:0] w2, logic [31:0] wb,
                                           logic [31:0] x1, logic [31:0] x2);
        longint s;
        s = longint'($signed(fxm(w1, x1))) + longint'($signed(fxm(w2, x2))) + longint'($signed(wb));
        return (s > 0) ? ONEF : 32'h0;
    endfunction

    always_comb neuron_out = use_neuron ? neuron(w1_out, w2_out, wb_out, x1_out, x2_out) : nout_drv;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_w1 = 32'h0; m_w2 = 32'h0; m_wb = 32'h0;
        m_cnt = 0; m_err = 0; m_eerr = 0; m_conv = 1'b0;
    endtask

    task automatic model_step(logic [31:0] x1, logic [31:0] x2, logic t, logic te, logic [31:0] nout);
        e_pred = (nout == ONEF);
        e_err  = (e_pred != t);
        if (te && e_err) begin
            m_w1 = wupd(m_w1, fxm(LR, x1), !t);
            m_w2 = wupd(m_w2, fxm(LR, x2), !t);
            m_wb = wupd(m_wb, fxm(LR, BIAS), !t);
        end
        if (e_err) m_err++;
        e_edone = (m_cnt == NS - 1);
        if (e_edone) begin
            m_eerr = m_err; m_conv = (m_err == 0); m_cnt = 0; m_err = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Entered and left just after a falling edge; checks the 3-cycle protocol.
    task automatic do_sample(logic [31:0] x1, logic [31:0] x2, logic t, logic te, logic [31:0] nout);
        sample_x1 = x1; sample_x2 = x2; sample_target = t; train_en = te; nout_drv = nout;
        sample_valid = 1'b1;
        chk("ready_idle", sample_ready, 1);
        @(negedge clk);
        sample_valid = 1'b0;
        sample_x1 = $urandom; sample_x2 = $urandom;
        chk("ready_eval", sample_ready, 0);
        chk("rvalid_eval", result_valid, 0);
        chk("x1_out", x1_out, x1);
        chk("x2_out", x2_out, x2);
        @(negedge clk);
        chk("rvalid_upd", result_valid, 1);
        chk("ready_upd", sample_ready, 0);
        obs_pred = result_pred; obs_err = result_error; obs_edone = epoch_done;
        @(negedge clk);
        chk("ready_after", sample_ready, 1);
        chk("rvalid_after", result_valid, 0);
        chk("edone_after", epoch_done, 0);
        obs_w1 = w1_out; obs_w2 = w2_out; obs_wb = wb_out;
        obs_eerr = epoch_errors; obs_conv = converged;
    endtask

    task automatic run_model(logic [31:0] x1, logic [31:0] x2, logic t, logic te, logic [31:0] nout);
        logic [31:0] nm;
        nm = use_neuron ? neuron(m_w1, m_w2, m_wb, x1, x2) : nout;
        do_sample(x1, x2, t, te, nout);
        model_step(x1, x2, t, te, nm);
        chk("m_pred", obs_pred, e_pred);
        chk("m_err", obs_err, e_err);
        chk("m_edone", obs_edone, e_edone);
        chk("m_w1", obs_w1, m_w1);
        chk("m_w2", obs_w2, m_w2);
        chk("m_wb", obs_wb, m_wb);
        chk("m_eerr", obs_eerr, m_eerr);
        chk("m_conv", obs_conv, m_conv);
    endtask

    initial begin
        logic [31:0] and_x1[4];
        logic [31:0] and_x2[4];
        logic        and_t[4];
        logic [31:0] nout;
        int unsigned k;

        rst = 1'b1; train_en = 1'b0; sample_valid = 1'b0; sample_target = 1'b0;
        sample_x1 = '0; sample_x2 = '0; nout_drv = '0; use_neuron = 1'b0;

        tbl[0] = '{32'h0001_0000, 32'h0, 1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 1'b0,
                   32'h0000_8000, 32'h0, 32'h0000_8000, 3'd0, 1'b0};
        tbl[1] = '{32'h0001_0000, 32'h0, 1'b0, 1'b1, 32'h0001_0000, 1'b1, 1'b1, 1'b0,
                   32'h0, 32'h0, 32'h0, 3'd0, 1'b0};
        tbl[2] = '{32'h0001_0000, 32'h0, 1'b0, 1'b0, 32'h0001_0000, 1'b1, 1'b1, 1'b0,
                   32'h0, 32'h0, 32'h0, 3'd0, 1'b0};
        tbl[3] = '{32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b1, 1'b0, 1'b1,
                   32'h0, 32'h0, 32'h0, 3'd3, 1'b0};

        and_x1 = '{32'h0, 32'h0, ONEF, ONEF};
        and_x2 = '{32'h0, ONEF, 32'h0, ONEF};
        and_t  = '{1'b0, 1'b0, 1'b0, 1'b1};

        // reset state
        apply_reset();
        chk("rst_w1", w1_out, 0);
        chk("rst_w2", w2_out, 0);
        chk("rst_wb", wb_out, 0);
        chk("rst_ready", sample_ready, 1);
        chk("rst_rvalid", result_valid, 0);
        chk("rst_edone", epoch_done, 0);
        chk("rst_eerr", epoch_errors, 0);
        chk("rst_conv", converged, 0);
        chk("rst_x1", x1_out, 0);

        // directed learning-rule vectors
        for (int i = 0; i < 4; i++) begin
            do_sample(tbl[i].x1, tbl[i].x2, tbl[i].t, tbl[i].te, tbl[i].nout);
            chk($sformatf("tbl%0d_pred", i), obs_pred, tbl[i].pred);
            chk($sformatf("tbl%0d_err", i), obs_err, tbl[i].err);
            chk($sformatf("tbl%0d_edone", i), obs_edone, tbl[i].edone);
            chk($sformatf("tbl%0d_w1", i), obs_w1, tbl[i].w1);
            chk($sformatf("tbl%0d_w2", i), obs_w2, tbl[i].w2);
            chk($sformatf("tbl%0d_wb", i), obs_wb, tbl[i].wb);
            chk($sformatf("tbl%0d_eerr", i), obs_eerr, tbl[i].eerr);
            chk($sformatf("tbl%0d_conv", i), obs_conv, tbl[i].conv);
            model_step(tbl[i].x1, tbl[i].x2, tbl[i].t, tbl[i].te, tbl[i].nout);
        end

        // randomized samples with idle gaps
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            k = $urandom_range(0, 3);
            nout = (k == 0) ? 32'h0 : (k == 1) ? ONEF : (k == 2) ? (ONEF + 32'h1) : $urandom;
            run_model($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nout);
        end

        // AND-gate training with the neuron attached
        apply_reset();
        use_neuron = 1'b1;
        for (int ep = 0; ep < 10; ep++)
            for (int s = 0; s < 4; s++)
                run_model(and_x1[s], and_x2[s], and_t[s], 1'b1, 32'h0);
        chk("and_conv", converged, 1);
        chk("and_eerr", epoch_errors, 0);
        for (int s = 0; s < 4; s++)
            run_model(and_x1[s], and_x2[s], and_t[s], 1'b1, 32'h0);
        chk("and_conv_hold", converged, 1);
        chk("and_eerr_hold", epoch_errors, 0);
        use_neuron = 1'b0;

        // reset while a sample is in EVAL
        run_model(ONEF, ONEF, 1'b1, 1'b1, 32'h0);
        run_model(ONEF, 32'h0, 1'b1, 1'b1, 32'h0);
        sample_x1 = ONEF; sample_x2 = ONEF; sample_target = 1'b1; train_en = 1'b1;
        nout_drv = 32'h0; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("mid_ready", sample_ready, 1);
        chk("mid_rvalid", result_valid, 0);
        chk("mid_w1", w1_out, 0);
        chk("mid_w2", w2_out, 0);
        chk("mid_wb", wb_out, 0);
        @(negedge clk);
        chk("mid_rvalid2", result_valid, 0);
        for (int i = 0; i < 4; i++)
            run_model($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1,
                      (i % 2 == 0) ? ONEF : 32'h0);

        // overflow of w1 in the second instance
        apply_reset();
        chk("ovf_init", b_w1_out, 32'h7FFF_0000);
        do_sample(32'h7FFF_0000, 32'h0, 1'b1, 1'b1, 32'h0);
`ifdef PERCEPTRON_TRAINER_SAT_EN
        chk("ovf_w1", b_w1_out, 32'h7FFF_FFFF);
`else
        chk("ovf_w1", b_w1_out, 32'hFFFE_0000);
`endif
        chk("ovf_w2", b_w2_out, 32'h0);
        chk("ovf_wb", b_wb_out, 32'h0001_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
